// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus definitions: sprite-DMA state encoding and fixed register/OAM addresses.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT,
    ST_ALIGN,
    ST_READ,
    ST_WRITE
  } oam_dma_state_t;

  localparam logic [15:0] OAM_DATA_ADDR    = 16'h2004;
  localparam logic [15:0] OAM_DMA_REG_ADDR = 16'h4014;
  localparam int          OAM_DMA_LEN      = 256;

endpackage

// File: rtl/oam_dma.sv
// Sprite-DMA bus master: stalls the CPU and copies one 256-byte page to $2004, 513/514 cycles, no backpressure.
// OAM_DMA_ALIGN_EN inserts one ALIGN cycle so the first READ always lands on parity 0.
module oam_dma
  import nes_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  page,
  output logic        cpu_halt,
  output logic        busy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_oe,
  input  logic [7:0]  bus_din,
  output logic        bus_rw_n,
  output logic        bus_cs_n,
  output logic        parity
);

  localparam logic [15:0] OAM_ADDR = OAM_DATA_ADDR;
  localparam logic [7:0]  LAST_IDX = 8'(OAM_DMA_LEN - 1);
`ifdef OAM_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  oam_dma_state_t state;
  logic [7:0]     pg;
  logic [7:0]     idx;

  // Bus strobes default to idle each cycle; only READ/WRITE entries assert them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      pg       <= 8'h00;
      idx      <= 8'h00;
      parity   <= 1'b0;
      cpu_halt <= 1'b0;
      busy     <= 1'b0;
      bus_addr <= 16'h0000;
      bus_dout <= 8'h00;
      bus_oe   <= 1'b0;
      bus_rw_n <= 1'b1;
      bus_cs_n <= 1'b1;
    end else begin
      parity   <= ~parity;
      bus_cs_n <= 1'b1;
      bus_rw_n <= 1'b1;
      bus_oe   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            pg       <= page;
            idx      <= 8'h00;
            cpu_halt <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_HALT;
          end
        end
        ST_HALT: begin
          // Next cycle has parity ~parity; align when that would be odd.
          if (ALIGN_EN && !parity) begin
            state <= ST_ALIGN;
          end else begin
            state    <= ST_READ;
            bus_addr <= {pg, idx};
            bus_cs_n <= 1'b0;
          end
        end
        ST_ALIGN: begin
          state    <= ST_READ;
          bus_addr <= {pg, idx};
          bus_cs_n <= 1'b0;
        end
        ST_READ: begin
          bus_dout <= bus_din;
          state    <= ST_WRITE;
          bus_addr <= OAM_ADDR;
          bus_cs_n <= 1'b0;
          bus_rw_n <= 1'b0;
          bus_oe   <= 1'b1;
        end
        ST_WRITE: begin
          if (idx == LAST_IDX) begin
            state    <= ST_IDLE;
            cpu_halt <= 1'b0;
            busy     <= 1'b0;
          end else begin
            idx      <= idx + 8'd1;
            state    <= ST_READ;
            bus_addr <= {pg, idx + 8'd1};
            bus_cs_n <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_oam_dma.sv
// Randomized bench for oam_dma: a memory model serves reads, and each transfer is compared against the copy/stall rules.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  page = 8'h00;
  logic        cpu_halt, busy, bus_oe, bus_rw_n, bus_cs_n, parity;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout, bus_din;

`ifdef OAM_DMA_ALIGN_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  oam_dma dut (
    .clk(clk), .rst(rst), .start(start), .page(page),
    .cpu_halt(cpu_halt), .busy(busy), .bus_addr(bus_addr), .bus_dout(bus_dout),
    .bus_oe(bus_oe), .bus_din(bus_din), .bus_rw_n(bus_rw_n), .bus_cs_n(bus_cs_n),
    .parity(parity)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];
  assign bus_din = (!bus_cs_n && bus_rw_n) ? mem[bus_addr] : 8'hEE;

  // Reference CPU-cycle parity: cleared by reset, flips on every clock.
  logic tb_par;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_par <= 1'b0;
    else     tb_par <= ~tb_par;
  end

  int errors = 0;
  int checks = 0;

  logic [15:0] rd_addr[$];
  logic        rd_par[$];
  logic [15:0] wr_addr[$];
  logic [7:0]  wr_dat[$];
  int   stall, oe_bad, busy_bad, par_bad, extra;
  logic timeout, aborted, first_halt;
  logic [3:0] post;

  // Drive one transfer and record everything seen on the bus; start lands so HALT has parity halt_par.
  task automatic run_xfer(input logic [7:0] pg, input logic halt_par, input int inject_at, input int rst_at);
    rd_addr.delete(); rd_par.delete(); wr_addr.delete(); wr_dat.delete();
    stall = 0; oe_bad = 0; busy_bad = 0; par_bad = 0; extra = 0;
    timeout = 1'b0; aborted = 1'b0; post = 4'h0;
    @(negedge clk);
    if (tb_par == halt_par) @(negedge clk);
    start = 1'b1; page = pg;
    @(negedge clk);
    start = 1'b0; page = 8'($urandom);
    first_halt = cpu_halt;
    for (int n = 0; n < 700 && cpu_halt; n++) begin
      stall++;
      start = 1'b0;
      if (busy !== cpu_halt) busy_bad++;
      if (parity !== tb_par) par_bad++;
      if (bus_cs_n && bus_oe) oe_bad++;
      if (!bus_cs_n && bus_rw_n) begin
        rd_addr.push_back(bus_addr);
        rd_par.push_back(tb_par);
        if (bus_oe) oe_bad++;
        if (rd_addr.size() == inject_at) begin start = 1'b1; page = 8'h07; end
        if (rd_addr.size() == rst_at) begin
          rst = 1'b1;
          @(negedge clk);
          post = {cpu_halt, busy, bus_cs_n, bus_oe};
          rst = 1'b0;
          aborted = 1'b1;
          break;
        end
      end
      if (!bus_cs_n && !bus_rw_n) begin
        wr_addr.push_back(bus_addr);
        wr_dat.push_back(bus_dout);
        if (!bus_oe) oe_bad++;
      end
      @(negedge clk);
    end
    if (cpu_halt && !aborted) timeout = 1'b1;
    start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (!bus_cs_n || cpu_halt || bus_oe) extra++;
    end
  endtask

  // Mismatches between the recorded bus trace and an in-order copy of page pg.
  function automatic int seq_bad(input logic [7:0] pg, input logic rpar);
    int b = 0;
    if (rd_addr.size() != 256 || wr_addr.size() != 256 || wr_dat.size() != 256) return 1000;
    for (int i = 0; i < 256; i++) begin
      if (rd_addr[i] !== {pg, 8'(i)})        b++;
      if (rd_par[i]  !== rpar)               b++;
      if (wr_addr[i] !== 16'h2004)           b++;
      if (wr_dat[i]  !== mem[{pg, 8'(i)}])   b++;
    end
    return b;
  endfunction

  function automatic int exp_stall(input logic halt_par);
    return 513 + ((ALIGN_EN && !halt_par) ? 1 : 0);
  endfunction

  function automatic logic exp_rpar(input logic halt_par);
    return (ALIGN_EN && !halt_par) ? halt_par : ~halt_par;
  endfunction

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({cpu_halt, busy, bus_addr, bus_dout, bus_oe, bus_rw_n, bus_cs_n, parity} !==
        {1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got halt=%b busy=%b addr=%h dout=%h oe=%b rw_n=%b cs_n=%b par=%b want 0 0 0000 00 0 1 1 0",
               cpu_halt, busy, bus_addr, bus_dout, bus_oe, bus_rw_n, bus_cs_n, parity);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (parity !== tb_par || cpu_halt !== 1'b0 || bus_cs_n !== 1'b1) begin
      errors++;
      $display("FAIL idle_parity got par=%b halt=%b cs_n=%b want par=%b halt=0 cs_n=1", parity, cpu_halt, bus_cs_n, tb_par);
    end
  endtask

  task automatic check_xfer(input string name, input logic [7:0] pg, input logic hp);
    int sb;
    sb = seq_bad(pg, exp_rpar(hp));
    checks++;
    if (first_halt !== 1'b1 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL %s_start got halt_at_T1=%b timeout=%b want 1 0", name, first_halt, timeout);
    end
    checks++;
    if (stall !== exp_stall(hp)) begin
      errors++;
      $display("FAIL %s_stall got %0d cycles want %0d", name, stall, exp_stall(hp));
    end
    checks++;
    if (sb !== 0) begin
      errors++;
      $display("FAIL %s_sequence got %0d bad entries (reads=%0d writes=%0d) want 0", name, sb, rd_addr.size(), wr_dat.size());
    end
    checks++;
    if (oe_bad + busy_bad + par_bad !== 0) begin
      errors++;
      $display("FAIL %s_strobes got oe_bad=%0d busy_bad=%0d par_bad=%0d want 0 0 0", name, oe_bad, busy_bad, par_bad);
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL %s_after_end got %0d active cycles want 0", name, extra);
    end
  endtask

  task automatic test_no_align;
    run_xfer(8'h02, 1'b1, 0, 0);
    check_xfer("no_align", 8'h02, 1'b1);
  endtask

  task automatic test_align;
    run_xfer(8'h02, 1'b0, 0, 0);
    check_xfer("align", 8'h02, 1'b0);
  endtask

  task automatic test_ignore_start;
    run_xfer(8'h02, 1'b1, 100, 0);
    check_xfer("ignore_start", 8'h02, 1'b1);
  endtask

  task automatic test_page_ff;
    logic hp;
    hp = 1'($urandom);
    run_xfer(8'hFF, hp, 0, 0);
    check_xfer("page_ff", 8'hFF, hp);
    checks++;
    if (rd_addr.size() == 0 || rd_addr[rd_addr.size()-1] !== 16'hFFFF) begin
      errors++;
      $display("FAIL page_ff_last_read got %h want ffff", (rd_addr.size() == 0) ? 16'h0 : rd_addr[rd_addr.size()-1]);
    end
  endtask

  task automatic test_mid_reset;
    logic [7:0] pg;
    logic       hp;
    run_xfer(8'h02, 1'b1, 0, 37);
    checks++;
    if (aborted !== 1'b1 || post !== 4'b0010) begin
      errors++;
      $display("FAIL mid_reset_outputs got aborted=%b {halt,busy,cs_n,oe}=%b want 1 0010", aborted, post);
    end
    checks++;
    if (extra !== 0 || rd_addr.size() !== 37) begin
      errors++;
      $display("FAIL mid_reset_quiet got extra=%0d reads=%0d want 0 37", extra, rd_addr.size());
    end
    pg = 8'($urandom);
    hp = 1'($urandom);
    run_xfer(pg, hp, 0, 0);
    check_xfer("after_reset", pg, hp);
  endtask

  task automatic test_random;
    logic [7:0] pg;
    logic       hp;
    for (int k = 0; k < 3; k++) begin
      pg = 8'($urandom);
      hp = 1'($urandom);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_xfer(pg, hp, 0, 0);
      check_xfer("random", pg, hp);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
    test_reset();
    test_no_align();
    test_align();
    test_ignore_start();
    test_page_ff();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
